park_slot_allocator: RTL and testbench
======================================

Name: park_slot_allocator

Overview:
- Central occupancy controller for the car park.
- Tracks which parking slots are occupied.
- Arbitrates between two entry gates requesting a slot and assigns the lowest-index free slot.
- Returns that slot's 4-bit slot code (code = 15 - slot index, i.e. bitwise inverse of the index) and frees slots when an exit gate presents a code.
- Sits between the gate controllers and the display/ticket logic.

Parameters:
- N_SLOTS, 16, number of usable slots (1..16). Slot indices >= N_SLOTS are never allocated.
- RR_INIT, 0, entry gate holding round-robin priority after reset (0 or 1).

Ports:
- clk  in  1  system clock, all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ent_req  in  2  per-gate slot request, held high until that gate's ack
- ent_ack  out  2  one-hot, one-cycle grant pulse
- ent_code  out  4  slot code of the granted slot, valid while ent_ack != 0
- ent_full  out  1  high when no usable slot is free
- exit_valid  in  1  one-cycle strobe: a car leaves the slot given by exit_code
- exit_code  in  4  slot code of the leaving car
- exit_err  out  1  one-cycle pulse: exit_code names an unoccupied or unusable slot
- free_cnt  out  5  number of free usable slots
- occ  out  16  occupancy bitmap, bit i = slot i occupied; bits >= N_SLOTS always 0

Behaviour:
- Reset values:
  - occ = 0, free_cnt = N_SLOTS, ent_ack = 0, ent_code = 0, exit_err = 0.
  - ent_full = 0; if N_SLOTS = 0 were ever allowed it would be 1, but 0 is illegal.
  - State = IDLE, priority pointer = RR_INIT.
- FSM states:
  - IDLE: evaluates ent_req at each rising edge.
    - If any request is present and free_cnt != 0, go to ACK.
    - When both gates request, the gate named by the pointer wins.
    - The winner's occ bit is set and free_cnt is decremented at the same edge.
    - ent_ack[winner] = 1 and ent_code = ~slot_index are registered.
    - The pointer moves to the other gate.
  - ACK: lasts exactly one cycle.
    - ent_ack is visible during this cycle, then clears; ent_code returns to 0.
    - Requests are not evaluated in ACK.
    - Always returns to IDLE.
- Latency and handshake:
  - Request sampled at edge N -> ack high in cycle N+1.
  - The requester drops req at the edge ending the ack cycle.
  - Peak throughput is one grant per 2 cycles.
- Slot selection: the lowest index i < N_SLOTS with occ[i] = 0, computed from registered occ (start of cycle).
- Full condition: ent_full = (free_cnt == 0), combinational from registered state. While full, requests stay pending with no ack and no state change.
- Exit handling (processed in any state):
  - slot = ~exit_code.
  - If slot < N_SLOTS and occ[slot] = 1: clear the bit at the edge and increment free_cnt.
  - Otherwise: exit_err pulses for one cycle and occ is unchanged.
- Simultaneous exit and grant at the same edge:
  - Both are applied; free_cnt net change is 0.
  - The slot being freed is not a candidate for the grant in that cycle; it becomes allocatable on the next IDLE evaluation.
- Full with a simultaneous exit: no grant at that edge. Grant at the next IDLE edge if the request is still held.
- exit_valid naming the slot just granted in the same cycle cannot occur, because the slot was free at start of cycle; it reports exit_err.
- Reset mid-ACK: all outputs return to reset values immediately; the pending grant is lost and the gate re-requests.
- free_cnt never underflows or overflows; consistency free_cnt == N_SLOTS - popcount(occ) holds every cycle.

Decomposition:
- Shared package park_pkg holds:
  - CODE_W = 4, MAX_SLOTS = 16.
  - FSM state encoding (IDLE, ACK).
  - slot_to_code / code_to_slot functions, used by the gate controllers and display.
- One combinational sub-module park_free_finder: 16-bit bitmap plus N_SLOTS mask -> found flag and 4-bit lowest free index.

Test Plan:
1. Reset: assert rst_n = 0 mid-cycle -> immediately occ = 16'h0000, free_cnt = 16, ent_ack = 0, ent_full = 0.
2. Single request: gate0 req alone -> ent_ack = 2'b01 next cycle, ent_code = 4'b1111, occ = 16'h0001, free_cnt = 15. Repeat -> ent_code = 4'b1110, occ = 16'h0003.
3. Contention with RR_INIT = 0: both gates request together:
   - Gate0 acked first with code 1111.
   - Gate1 acked two cycles later with code 1110.
   - A repeat contention then favours gate1.
4. Fill to full: allocate all 16 slots -> ent_full = 1, free_cnt = 0.
   - Gate1 req held -> no ack.
   - exit_valid with exit_code = 4'b0101 -> bit10 clears, free_cnt = 1.
   - Next IDLE edge: gate1 acked with code 0101.
5. Bad exit: exit_code = 4'b0000 (slot15) while free -> exit_err one cycle, occ unchanged. With N_SLOTS = 10, 10 grants give ent_full = 1, and exit_code 4'b0011 (slot12) -> exit_err.
6. Simultaneous exit and grant, plus reset mid-ACK:
   - Exit of slot3 and a grant in the same edge -> free_cnt unchanged; granted slot != 3.
   - rst_n low during ACK -> ack drops immediately and occ is cleared.

Source files
------------

// File: rtl/park_pkg.sv
// Shared types and helpers for the car-park occupancy logic.
// Slot codes are the bitwise inverse of the slot index.
package park_pkg;

    localparam int CODE_W    = 4;
    localparam int MAX_SLOTS = 16;

    typedef enum logic {
        StIdle,
        StAck
    } state_t;

    function automatic logic [CODE_W-1:0] slot_to_code(input logic [CODE_W-1:0] slot);
        return ~slot;
    endfunction

    function automatic logic [CODE_W-1:0] code_to_slot(input logic [CODE_W-1:0] code);
        return ~code;
    endfunction

endpackage

// File: rtl/park_free_finder.sv
// Lowest-index free slot search over the occupancy bitmap, restricted to usable slots.
module park_free_finder
    import park_pkg::*;
(
    input  logic [MAX_SLOTS-1:0] occ,
    input  logic [MAX_SLOTS-1:0] mask,
    output logic                 found,
    output logic [CODE_W-1:0]    idx
);

    // Scan downwards so the lowest free index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (mask[i] && !occ[i]) begin
                found = 1'b1;
                idx   = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/park_slot_allocator.sv
// Occupancy controller: arbitrates two entry gates for the lowest free slot
// and releases slots on exit strobes.
module park_slot_allocator
    import park_pkg::*;
#(
    parameter int unsigned N_SLOTS = 16,
    parameter int unsigned RR_INIT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           ent_req,
    output logic [1:0]           ent_ack,
    output logic [CODE_W-1:0]    ent_code,
    output logic                 ent_full,
    input  logic                 exit_valid,
    input  logic [CODE_W-1:0]    exit_code,
    output logic                 exit_err,
    output logic [4:0]           free_cnt,
    output logic [MAX_SLOTS-1:0] occ
);

    localparam logic [MAX_SLOTS:0]   MASK_EXT  = (17'd1 << N_SLOTS) - 17'd1;
    localparam logic [MAX_SLOTS-1:0] SLOT_MASK = MASK_EXT[MAX_SLOTS-1:0];

    state_t                 state;
    logic                   rr;
    logic                   found;
    logic [CODE_W-1:0]      free_idx;
    logic [CODE_W-1:0]      ex_slot;
    logic                   exit_ok;
    logic                   grant;
    logic                   win;
    logic [MAX_SLOTS-1:0]   occ_d;
    logic [4:0]             cnt_d;

    park_free_finder u_finder (
        .occ   (occ),
        .mask  (SLOT_MASK),
        .found (found),
        .idx   (free_idx)
    );

    assign ent_full = (free_cnt == 5'd0);
    assign ex_slot  = code_to_slot(exit_code);
    assign exit_ok  = exit_valid && SLOT_MASK[ex_slot] && occ[ex_slot];
    assign grant    = (state == StIdle) && (|ent_req) && !ent_full && found;

    // Pointer only matters when both gates are requesting.
    always_comb begin
        if (ent_req == 2'b11) begin
            win = rr;
        end else begin
            win = ent_req[1];
        end
    end

    // A freed slot is occupied in registered occ, so it can never collide with the grant.
    always_comb begin
        occ_d = occ;
        if (grant) begin
            occ_d[free_idx] = 1'b1;
        end
        if (exit_ok) begin
            occ_d[ex_slot] = 1'b0;
        end
        cnt_d = free_cnt - 5'(grant) + 5'(exit_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            rr       <= RR_INIT[0];
            occ      <= '0;
            free_cnt <= 5'(N_SLOTS);
            ent_ack  <= 2'b00;
            ent_code <= '0;
            exit_err <= 1'b0;
        end else begin
            occ      <= occ_d;
            free_cnt <= cnt_d;
            exit_err <= exit_valid && !exit_ok;
            case (state)
                StIdle: begin
                    if (grant) begin
                        state    <= StAck;
                        ent_ack  <= win ? 2'b10 : 2'b01;
                        ent_code <= slot_to_code(free_idx);
                        rr       <= ~win;
                    end
                end
                StAck: begin
                    state    <= StIdle;
                    ent_ack  <= 2'b00;
                    ent_code <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_park_slot_allocator.sv
// Directed bench for park_slot_allocator: full-size instance plus a 10-slot instance.
module tb_park_slot_allocator;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic [3:0]  code;
    logic        full;
    logic        xv;
    logic [3:0]  xc;
    logic        xerr;
    logic [4:0]  fcnt;
    logic [15:0] occ;

    logic [1:0]  req10;
    logic [1:0]  ack10;
    logic [3:0]  code10;
    logic        full10;
    logic        xv10;
    logic [3:0]  xc10;
    logic        xerr10;
    logic [4:0]  fcnt10;
    logic [15:0] occ10;

    int n_checks = 0;
    int n_pass   = 0;

    park_slot_allocator #(.N_SLOTS(16), .RR_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ent_req    (req),
        .ent_ack    (ack),
        .ent_code   (code),
        .ent_full   (full),
        .exit_valid (xv),
        .exit_code  (xc),
        .exit_err   (xerr),
        .free_cnt   (fcnt),
        .occ        (occ)
    );

    park_slot_allocator #(.N_SLOTS(10), .RR_INIT(0)) dut10 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ent_req    (req10),
        .ent_ack    (ack10),
        .ent_code   (code10),
        .ent_full   (full10),
        .exit_valid (xv10),
        .exit_code  (xc10),
        .exit_err   (xerr10),
        .free_cnt   (fcnt10),
        .occ        (occ10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        req = 2'b00; xv = 1'b0; xc = 4'h0;
        req10 = 2'b00; xv10 = 1'b0; xc10 = 4'h0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); req = 2'b01;
        @(posedge clk); #1;
        @(negedge clk); req = 2'b00;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (occ !== 16'h0000) $display("FAIL reset_occ got %h want 0000", occ);
        else n_pass++;
        n_checks++;
        if (fcnt !== 5'd16) $display("FAIL reset_free_cnt got %0d want 16", fcnt);
        else n_pass++;
        n_checks++;
        if (ack !== 2'b00 || code !== 4'h0) $display("FAIL reset_ack got %b/%h want 00/0", ack, code);
        else n_pass++;
        n_checks++;
        if (full !== 1'b0 || xerr !== 1'b0) $display("FAIL reset_flags got full %b err %b want 0 0", full, xerr);
        else n_pass++;
        n_checks++;
        if (fcnt10 !== 5'd10) $display("FAIL reset_free_cnt10 got %0d want 10", fcnt10);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk); req = 2'b01;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 2'b01 || code !== 4'hF) $display("FAIL single1_ack got %b/%h want 01/f", ack, code);
        else n_pass++;
        n_checks++;
        if (occ !== 16'h0001 || fcnt !== 5'd15) $display("FAIL single1_occ got %h/%0d want 0001/15", occ, fcnt);
        else n_pass++;
        @(negedge clk); req = 2'b00;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 2'b00 || code !== 4'h0) $display("FAIL single_ack_clear got %b/%h want 00/0", ack, code);
        else n_pass++;
        @(negedge clk); req = 2'b01;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 2'b01 || code !== 4'hE) $display("FAIL single2_ack got %b/%h want 01/e", ack, code);
        else n_pass++;
        n_checks++;
        if (occ !== 16'h0003 || fcnt !== 5'd14) $display("FAIL single2_occ got %h/%0d want 0003/14", occ, fcnt);
        else n_pass++;
        @(negedge clk); req = 2'b00;
        @(posedge clk);
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk); req = 2'b11;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 2'b01 || code !== 4'hF) $display("FAIL cont_first got %b/%h want 01/f", ack, code);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 2'b00) $display("FAIL cont_ack_gap got %b want 00", ack);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 2'b10 || code !== 4'hE) $display("FAIL cont_second got %b/%h want 10/e", ack, code);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 2'b01 || code !== 4'hD) $display("FAIL cont_third got %b/%h want 01/d", ack, code);
        else n_pass++;
        n_checks++;
        if (occ !== 16'h0007 || fcnt !== 5'd13) $display("FAIL cont_occ got %h/%0d want 0007/13", occ, fcnt);
        else n_pass++;
        @(negedge clk); req = 2'b00;
        @(posedge clk);
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); req = 2'b01;
            @(posedge clk); #1;
            n_checks++;
            if (ack !== 2'b01 || code !== 4'(15 - i))
                $display("FAIL fill_grant%0d got %b/%h want 01/%h", i, ack, code, 4'(15 - i));
            else n_pass++;
            @(negedge clk); req = 2'b00;
            @(posedge clk);
        end
        #1;
        n_checks++;
        if (full !== 1'b1 || fcnt !== 5'd0 || occ !== 16'hFFFF)
            $display("FAIL fill_full got %b/%0d/%h want 1/0/ffff", full, fcnt, occ);
        else n_pass++;
        @(negedge clk); req = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ack !== 2'b00) $display("FAIL full_no_ack%0d got %b want 00", i, ack);
            else n_pass++;
        end
        @(negedge clk); xv = 1'b1; xc = 4'b0101;
        @(posedge clk); #1;
        n_checks++;
        if (occ !== 16'hFBFF || fcnt !== 5'd1 || ack !== 2'b00 || xerr !== 1'b0)
            $display("FAIL full_exit got %h/%0d/%b/%b want fbff/1/00/0", occ, fcnt, ack, xerr);
        else n_pass++;
        @(negedge clk); xv = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 2'b10 || code !== 4'h5 || occ !== 16'hFFFF || fcnt !== 5'd0)
            $display("FAIL full_regrant got %b/%h/%h/%0d want 10/5/ffff/0", ack, code, occ, fcnt);
        else n_pass++;
        @(negedge clk); req = 2'b00;
        @(posedge clk);
    endtask

    task automatic test_bad_exit();
        do_reset();
        @(negedge clk); xv = 1'b1; xc = 4'b0000;
        @(posedge clk); #1;
        n_checks++;
        if (xerr !== 1'b1 || occ !== 16'h0000 || fcnt !== 5'd16)
            $display("FAIL bad_exit got %b/%h/%0d want 1/0000/16", xerr, occ, fcnt);
        else n_pass++;
        @(negedge clk); xv = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (xerr !== 1'b0) $display("FAIL bad_exit_pulse got %b want 0", xerr);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); req10 = 2'b10;
            @(posedge clk); #1;
            n_checks++;
            if (ack10 !== 2'b10 || code10 !== 4'(15 - i))
                $display("FAIL n10_grant%0d got %b/%h want 10/%h", i, ack10, code10, 4'(15 - i));
            else n_pass++;
            @(negedge clk); req10 = 2'b00;
            @(posedge clk);
        end
        #1;
        n_checks++;
        if (full10 !== 1'b1 || fcnt10 !== 5'd0 || occ10 !== 16'h03FF)
            $display("FAIL n10_full got %b/%0d/%h want 1/0/03ff", full10, fcnt10, occ10);
        else n_pass++;
        @(negedge clk); xv10 = 1'b1; xc10 = 4'b0011;
        @(posedge clk); #1;
        n_checks++;
        if (xerr10 !== 1'b1 || occ10 !== 16'h03FF || fcnt10 !== 5'd0)
            $display("FAIL n10_bad_exit got %b/%h/%0d want 1/03ff/0", xerr10, occ10, fcnt10);
        else n_pass++;
        @(negedge clk); xv10 = 1'b0;
    endtask

    task automatic test_sim_exit_grant();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); req = 2'b01;
            @(posedge clk);
            @(negedge clk); req = 2'b00;
            @(posedge clk);
        end
        @(negedge clk); req = 2'b01; xv = 1'b1; xc = 4'hC;
        @(posedge clk); #1;
        n_checks++;
        if (fcnt !== 5'd11 || occ !== 16'h0037)
            $display("FAIL sim_state got %0d/%h want 11/0037", fcnt, occ);
        else n_pass++;
        n_checks++;
        if (ack !== 2'b01 || code !== 4'hA) $display("FAIL sim_grant got %b/%h want 01/a", ack, code);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ack !== 2'b00 || code !== 4'h0 || occ !== 16'h0000 || fcnt !== 5'd16)
            $display("FAIL reset_mid_ack got %b/%h/%h/%0d want 00/0/0000/16", ack, code, occ, fcnt);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1; req = 2'b00; xv = 1'b0;
        @(negedge clk); req = 2'b01;
        @(posedge clk); #1;
        n_checks++;
        if (ack !== 2'b01 || code !== 4'hF) $display("FAIL after_reset_grant got %b/%h want 01/f", ack, code);
        else n_pass++;
        @(negedge clk); req = 2'b00;
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00; xv = 1'b0; xc = 4'h0;
        req10 = 2'b00; xv10 = 1'b0; xc10 = 4'h0;
        test_reset();
        test_single();
        test_contention();
        test_fill();
        test_bad_exit();
        test_sim_exit_grant();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
